aes_gcm_issue_ctrl: RTL

//  Front-end scheduler for the AES-GCM encrypt pipeline. It accepts one GCM instance config (J0 and bit lengths)

---
 rtl/aes_gcm_issue_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/aes_gcm_issue_ctrl.sv
// AES-GCM front-end issue controller: sequences INIT, AAD*, PT*, LEN beats per instance
// into pipeline stage 1, derives J0/inc32 counter blocks and throttles on returned credits.
module aes_gcm_issue_ctrl #(
  parameter int CNT_W   = 16,
  parameter int CREDITS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_cfg_valid,
  output logic         s_cfg_ready,
  input  logic [127:0] s_cfg_j0,
  input  logic [63:0]  s_cfg_aad_bits,
  input  logic [63:0]  s_cfg_pt_bits,
  input  logic         s_blk_valid,
  output logic         s_blk_ready,
  input  logic [127:0] s_blk_data,
  input  logic         i_credit_ret,
  output logic [2:0]   o_phase,
  output logic         o_new_instance,
  output logic [127:0] o_h,
  output logic [127:0] o_encrypted_j0,
  output logic [127:0] o_encrypted_cb,
  output logic [127:0] o_aad,
  output logic [127:0] o_plain_text,
  output logic [127:0] o_instance_size,
  output logic         o_busy,
  output logic         o_credit_err
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_INIT = 3'd1;
  localparam logic [2:0] PH_AAD  = 3'd2;
  localparam logic [2:0] PH_PT   = 3'd3;
  localparam logic [2:0] PH_LEN  = 3'd4;

  typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_AAD, ST_PT, ST_LEN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_aad_rem;
  logic [CNT_W-1:0] r_pt_rem;
  logic [CW-1:0]    r_credit;
  logic             r_credit_err;
  logic [127:0]     r_j0;
  logic [127:0]     r_cb;
  logic [127:0]     r_size;

  logic [2:0]       r_phase_p1;
  logic             r_new_p1;
  logic [127:0]     r_j0_p1;
  logic [127:0]     r_cb_p1;
  logic [127:0]     r_aad_p1;
  logic [127:0]     r_pt_p1;
  logic [127:0]     r_size_p1;

  logic w_idle;
  logic w_has_credit;
  logic w_cfg_acc;
  logic w_issue;
  logic w_credit_sat;

  // Block count from a bit length; upper bits beyond CNT_W blocks are dropped.
  function automatic logic [CNT_W-1:0] blk_count(input logic [63:0] bits);
    logic [64:0] sum;
    sum = {1'b0, bits} + 65'd127;
    return CNT_W'(sum >> 7);
  endfunction

  function automatic logic [127:0] inc32(input logic [127:0] b);
    return {b[127:32], b[31:0] + 32'd1};
  endfunction

  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cnt,
                                                input logic iss, input logic ret);
    if (iss && !ret) return cnt - CW'(1);
    if (ret && !iss && cnt != CW'(CREDITS)) return cnt + CW'(1);
    return cnt;
  endfunction

  assign w_idle       = (r_state == ST_IDLE);
  assign w_has_credit = (r_credit != '0);
  assign s_cfg_ready  = w_idle & ~rst;
  assign w_cfg_acc    = s_cfg_valid & s_cfg_ready;
  assign s_blk_ready  = ((r_state == ST_AAD) || (r_state == ST_PT)) && w_has_credit;
  assign w_credit_sat = i_credit_ret & ~w_issue & (r_credit == CW'(CREDITS));

  always_comb begin
    w_issue = 1'b0;
    case (r_state)
      ST_INIT, ST_LEN: w_issue = w_has_credit;
      ST_AAD, ST_PT:   w_issue = w_has_credit & s_blk_valid;
      default:         w_issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_aad_rem    <= '0;
      r_pt_rem     <= '0;
      r_credit     <= CW'(CREDITS);
      r_credit_err <= 1'b0;
      r_phase_p1   <= PH_IDLE;
      r_new_p1     <= 1'b0;
      r_j0_p1      <= '0;
      r_cb_p1      <= '0;
      r_aad_p1     <= '0;
      r_pt_p1      <= '0;
      r_size_p1    <= '0;
    end else begin
      r_credit <= credit_next(r_credit, w_issue, i_credit_ret);
      if (w_credit_sat) r_credit_err <= 1'b1;
      // Stage p1: bubble unless a beat is issued this cycle
      r_phase_p1 <= PH_IDLE;
      r_new_p1   <= 1'b0;
      r_j0_p1    <= '0;
      r_cb_p1    <= '0;
      r_aad_p1   <= '0;
      r_pt_p1    <= '0;
      r_size_p1  <= '0;
      if (w_issue) begin
        r_j0_p1   <= r_j0;
        r_size_p1 <= r_size;
      end
      case (r_state)
        ST_IDLE: if (w_cfg_acc) begin
          r_aad_rem <= blk_count(s_cfg_aad_bits);
          r_pt_rem  <= blk_count(s_cfg_pt_bits);
          r_state   <= ST_INIT;
        end
        ST_INIT: if (w_issue) begin
          r_phase_p1 <= PH_INIT;
          r_new_p1   <= 1'b1;
          r_state    <= (r_aad_rem != '0) ? ST_AAD : (r_pt_rem != '0) ? ST_PT : ST_LEN;
        end
        ST_AAD: if (w_issue) begin
          r_phase_p1 <= PH_AAD;
          r_aad_p1   <= s_blk_data;
          r_aad_rem  <= r_aad_rem - ONE_CNT;
          if (r_aad_rem == ONE_CNT) r_state <= (r_pt_rem != '0) ? ST_PT : ST_LEN;
        end
        ST_PT: if (w_issue) begin
          r_phase_p1 <= PH_PT;
          r_cb_p1    <= r_cb;
          r_pt_p1    <= s_blk_data;
          r_pt_rem   <= r_pt_rem - ONE_CNT;
          if (r_pt_rem == ONE_CNT) r_state <= ST_LEN;
        end
        ST_LEN: if (w_issue) begin
          r_phase_p1 <= PH_LEN;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Instance data registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    if (w_cfg_acc) begin
      r_j0   <= s_cfg_j0;
      r_size <= {s_cfg_aad_bits, s_cfg_pt_bits};
    end
    if (w_issue && r_state == ST_INIT) r_cb <= inc32(r_j0);
    else if (w_issue && r_state == ST_PT) r_cb <= inc32(r_cb);
  end

  assign o_phase         = r_phase_p1;
  assign o_new_instance  = r_new_p1;
  assign o_h             = '0;
  assign o_encrypted_j0  = r_j0_p1;
  assign o_encrypted_cb  = r_cb_p1;
  assign o_aad           = r_aad_p1;
  assign o_plain_text    = r_pt_p1;
  assign o_instance_size = r_size_p1;
  assign o_busy          = ~w_idle;
  assign o_credit_err    = r_credit_err;

endmodule
